mux_arb_n: RTL and testbench



---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_arb_n_if.sv | 40 ++++
 rtl/mux_arb_n_rr_pick.sv | 28 ++
 rtl/mux_arb_n.sv | 104 ++++++++++
 tb/tb_mux_arb_n.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the N-to-1 registered arbitrating multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the MODE input.
//   DEFAULT_WIDTH        : default data width per channel.
//   GRANT_CNT_W          : width of the optional handshake counter
//                          (built only when MUX_GRANT_CNT_EN is defined).
package mux_pkg;

  localparam logic MODE_FIXED    = 1'b0;
  localparam logic MODE_RR       = 1'b1;
  localparam int   DEFAULT_WIDTH = 32;
  localparam int   GRANT_CNT_W   = 16;

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: channel-side and consumer-side signals of mux_arb_n.
//   D        N*WIDTH packed channel data, channel i = D[i*WIDTH +: WIDTH]
//   D_VALID  N       per-channel valid
//   D_READY  N       per-channel transfer strobe (one-hot or zero)
//   MODE     1       0 = fixed select by S, 1 = round-robin
//   S        SEL_W   channel index in fixed mode
//   Y        WIDTH   registered selected data
//   Y_VALID  1       Y holds valid data
//   Y_READY  1       consumer accepts Y
//   Y_SEL    SEL_W   channel that produced Y
// Modports: slave = the multiplexer, master = producers/consumer side.
interface mux_arb_n_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] D;
  logic [N-1:0]       D_VALID;
  logic [N-1:0]       D_READY;
  logic               MODE;
  logic [SEL_W-1:0]   S;
  logic [WIDTH-1:0]   Y;
  logic               Y_VALID;
  logic               Y_READY;
  logic [SEL_W-1:0]   Y_SEL;

  modport slave (
    input  D, D_VALID, MODE, S, Y_READY,
    output D_READY, Y, Y_VALID, Y_SEL
  );

  modport master (
    output D, D_VALID, MODE, S, Y_READY,
    input  D_READY, Y, Y_VALID, Y_SEL
  );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req         N      request vector
//   ptr         SEL_W  highest-priority index (must be < N)
//   grant       SEL_W  first requesting index at or after ptr, wrapping N-1 -> 0
//   grant_valid 1      at least one request present
module rr_pick #(
  parameter int  N     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  // Walk the offsets from ptr; the modulo keeps non-power-of-two N in range.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && req[(int'(ptr) + k) % N]) begin
        grant       = SEL_W'((int'(ptr) + k) % N);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-to-1 WIDTH-bit registered multiplexer with valid/ready per channel.
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   bus        mux_arb_n_if.slave (D, D_VALID, D_READY, MODE, S, Y, Y_VALID, Y_READY, Y_SEL)
// Optional (macro MUX_GRANT_CNT_EN):
//   CNT_CLR    synchronous clear of GRANT_CNT, wins over increment
//   GRANT_CNT  saturating count of output handshakes (Y_VALID && Y_READY)
// The interface instance must be built with the same WIDTH and N.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 8
) (
  input  logic clk,
  input  logic reset,
  mux_arb_n_if.slave bus
`ifdef MUX_GRANT_CNT_EN
  ,
  input  logic                   CNT_CLR,
  output logic [GRANT_CNT_W-1:0] GRANT_CNT
`endif
);

  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;
  logic [SEL_W-1:0] y_sel_q;
  logic [SEL_W-1:0] ptr_q;

  logic             load_en;
  logic             fix_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             xfer;

  rr_pick #(.N(N)) u_rr_pick (
    .req         (bus.D_VALID),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Compare S against every legal index so S >= N simply never matches.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.S == SEL_W'(i)) fix_valid = bus.D_VALID[i];
    end
  end

  assign grant       = (bus.MODE == MODE_RR) ? rr_grant : bus.S;
  assign grant_valid = (bus.MODE == MODE_RR) ? rr_valid : fix_valid;
  assign load_en     = !y_valid_q || bus.Y_READY;
  assign xfer        = load_en && grant_valid && !reset;

  always_comb begin
    bus.D_READY = '0;
    if (xfer) bus.D_READY[grant] = 1'b1;
  end

  // Output register; the pointer only advances on round-robin transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sel_q   <= '0;
      ptr_q     <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        y_q       <= bus.D[int'(grant)*WIDTH +: WIDTH];
        y_sel_q   <= grant;
        y_valid_q <= 1'b1;
        if (bus.MODE == MODE_RR) begin
          ptr_q <= (grant == SEL_W'(N-1)) ? '0 : grant + 1'b1;
        end
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign bus.Y       = y_q;
  assign bus.Y_VALID = y_valid_q;
  assign bus.Y_SEL   = y_sel_q;

`ifdef MUX_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || CNT_CLR) begin
      cnt_q <= '0;
    end else if (y_valid_q && bus.Y_READY && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign GRANT_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: self-checking bench for mux_arb_n.
//   dut8 (N=8) is tracked cycle by cycle against a behavioural model.
//   dut5 (N=5) covers the non-power-of-two select range with directed checks.
// With MUX_GRANT_CNT_EN defined the handshake counter is modelled and checked too.
module tb_mux_arb_n;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst8;
  logic rst5;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mux_arb_n_if #(.WIDTH(32), .N(8)) bus8 ();
  mux_arb_n_if #(.WIDTH(32), .N(5)) bus5 ();

`ifdef MUX_GRANT_CNT_EN
  logic        cnt_clr8, cnt_clr5;
  logic [15:0] grant_cnt8, grant_cnt5;
`endif

  mux_arb_n #(.WIDTH(32), .N(8)) dut8 (
    .clk       (clk),
    .reset     (rst8),
    .bus       (bus8)
`ifdef MUX_GRANT_CNT_EN
    ,
    .CNT_CLR   (cnt_clr8),
    .GRANT_CNT (grant_cnt8)
`endif
  );

  mux_arb_n #(.WIDTH(32), .N(5)) dut5 (
    .clk       (clk),
    .reset     (rst5),
    .bus       (bus5)
`ifdef MUX_GRANT_CNT_EN
    ,
    .CNT_CLR   (cnt_clr5),
    .GRANT_CNT (grant_cnt5)
`endif
  );

  // Behavioural model of dut8: what the consumer should see.
  logic [31:0] m_y;
  logic        m_yv;
  int          m_sel;
  int          m_ptr;
  int          m_cnt;

  // Fixed: S names a valid channel. Round-robin: lowest requesting index
  // not below the pointer, else the lowest requesting index overall.
  function automatic int model_grant(input logic mode, input int s, input logic [7:0] v, input int ptr);
    int best;
    best = -1;
    if (mode == MODE_FIXED) begin
      if (s < 8 && v[s]) best = s;
    end else begin
      for (int i = 7; i >= ptr; i--) if (v[i]) best = i;
      if (best < 0) for (int i = 7; i >= 0; i--) if (v[i]) best = i;
    end
    return best;
  endfunction

  // One cycle on dut8: check D_READY mid-cycle, advance model, check registers.
  task automatic tick8(input string tag);
    int          g;
    logic        load;
    logic [7:0]  exp_rdy;
    #1;
    load    = !m_yv || bus8.Y_READY;
    g       = model_grant(bus8.MODE, int'(bus8.S), bus8.D_VALID, m_ptr);
    exp_rdy = '0;
    if (!rst8 && load && g >= 0) exp_rdy[g] = 1'b1;
    n_cmp++;
    if (bus8.D_READY !== exp_rdy) begin
      n_bad++;
      $display("[TB] FAIL %s d_ready: got %h expected %h", tag, bus8.D_READY, exp_rdy);
    end
`ifdef MUX_GRANT_CNT_EN
    if (rst8 || cnt_clr8) m_cnt = 0;
    else if (m_yv && bus8.Y_READY && m_cnt < 65535) m_cnt++;
`endif
    if (rst8) begin
      m_y = '0; m_yv = 1'b0; m_sel = 0; m_ptr = 0;
    end else if (load) begin
      if (g >= 0) begin
        m_y   = bus8.D[g*32 +: 32];
        m_sel = g;
        m_yv  = 1'b1;
        if (bus8.MODE == MODE_RR) m_ptr = (g + 1) % 8;
      end else begin
        m_yv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus8.Y_VALID !== m_yv) begin
      n_bad++;
      $display("[TB] FAIL %s y_valid: got %b expected %b", tag, bus8.Y_VALID, m_yv);
    end
    n_cmp++;
    if (bus8.Y !== m_y || bus8.Y_SEL !== 3'(m_sel)) begin
      n_bad++;
      $display("[TB] FAIL %s y/y_sel: got %h/%0d expected %h/%0d", tag, bus8.Y, bus8.Y_SEL, m_y, m_sel);
    end
`ifdef MUX_GRANT_CNT_EN
    n_cmp++;
    if (grant_cnt8 !== 16'(m_cnt)) begin
      n_bad++;
      $display("[TB] FAIL %s grant_cnt: got %0d expected %0d", tag, grant_cnt8, m_cnt);
    end
`endif
  endtask

  task automatic rand_data8();
    for (int i = 0; i < 8; i++) bus8.D[i*32 +: 32] = $urandom;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    tick8("reset8");
    rst8 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1;
    bus8.D_VALID = 8'hFF; bus8.MODE = MODE_RR; bus8.S = 3'd0; bus8.Y_READY = 1'b1;
    rand_data8();
    tick8("reset_hold1");
    tick8("reset_hold2");
    n_cmp++;
    if (bus8.Y !== 32'h0 || bus8.Y_VALID !== 1'b0 || bus8.Y_SEL !== 3'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_values: got y=%h v=%b sel=%0d expected 0/0/0", bus8.Y, bus8.Y_VALID, bus8.Y_SEL);
    end
    rst8 = 1'b0;
    tick8("reset_first_grant");
    n_cmp++;
    if (bus8.Y_SEL !== 3'd0 || bus8.Y_VALID !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL first_rr_grant: got sel=%0d v=%b expected 0/1", bus8.Y_SEL, bus8.Y_VALID);
    end
  endtask

  task automatic test_fixed();
    bus8.MODE = MODE_FIXED; bus8.S = 3'd5; bus8.Y_READY = 1'b1;
    rand_data8();
    bus8.D[5*32 +: 32] = 32'hDEADBEEF;
    bus8.D_VALID = 8'h20;
    tick8("fixed_s5");
    n_cmp++;
    if (bus8.Y !== 32'hDEADBEEF || bus8.Y_SEL !== 3'd5) begin
      n_bad++;
      $display("[TB] FAIL fixed_data: got %h/%0d expected deadbeef/5", bus8.Y, bus8.Y_SEL);
    end
    bus8.D_VALID = 8'hDF;
    tick8("fixed_s_not_valid");
    bus8.S = 3'd0; bus8.D_VALID = 8'h01;
    tick8("fixed_s0");
  endtask

  task automatic test_rr_fair();
    reset8();
    bus8.MODE = MODE_RR; bus8.D_VALID = 8'hFF; bus8.Y_READY = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rand_data8();
      tick8("rr_fair");
      n_cmp++;
      if (bus8.Y_SEL !== 3'(k % 8)) begin
        n_bad++;
        $display("[TB] FAIL rr_sequence: got %0d expected %0d", bus8.Y_SEL, k % 8);
      end
    end
  endtask

  task automatic test_rr_sparse();
    reset8();
    bus8.MODE = MODE_RR; bus8.Y_READY = 1'b1;
    bus8.D_VALID = 8'h04;
    tick8("sparse_set_ptr3");
    bus8.D_VALID = 8'b1000_0100;
    tick8("sparse_first");
    n_cmp++;
    if (bus8.Y_SEL !== 3'd7) begin
      n_bad++;
      $display("[TB] FAIL sparse_grant7: got %0d expected 7", bus8.Y_SEL);
    end
    tick8("sparse_second");
    n_cmp++;
    if (bus8.Y_SEL !== 3'd2) begin
      n_bad++;
      $display("[TB] FAIL sparse_grant2: got %0d expected 2", bus8.Y_SEL);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bus8.MODE = MODE_RR; bus8.D_VALID = 8'hFF; bus8.Y_READY = 1'b1;
    rand_data8();
    tick8("bp_load");
    held = m_y;
    bus8.Y_READY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rand_data8();
      tick8("bp_stall");
      n_cmp++;
      if (bus8.Y !== held || bus8.Y_VALID !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL bp_hold: got %h/%b expected %h/1", bus8.Y, bus8.Y_VALID, held);
      end
    end
    bus8.Y_READY = 1'b1;
    tick8("bp_release");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst8 = ($urandom_range(0, 59) == 0);
      bus8.MODE = 1'($urandom_range(0, 1));
      bus8.S = 3'($urandom_range(0, 7));
      bus8.D_VALID = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      bus8.Y_READY = ($urandom_range(0, 3) != 0);
`ifdef MUX_GRANT_CNT_EN
      cnt_clr8 = ($urandom_range(0, 29) == 0);
`endif
      rand_data8();
      tick8("random");
    end
    rst8 = 1'b0;
`ifdef MUX_GRANT_CNT_EN
    cnt_clr8 = 1'b0;
`endif
  endtask

`ifdef MUX_GRANT_CNT_EN
  task automatic test_grant_cnt();
    reset8();
    bus8.MODE = MODE_RR; bus8.D_VALID = 8'hFF; bus8.Y_READY = 1'b1;
    for (int k = 0; k < 11; k++) begin
      rand_data8();
      tick8("cnt_run");
    end
    n_cmp++;
    if (grant_cnt8 !== 16'd10) begin
      n_bad++;
      $display("[TB] FAIL cnt_ten: got %0d expected 10", grant_cnt8);
    end
    cnt_clr8 = 1'b1;
    tick8("cnt_clr");
    cnt_clr8 = 1'b0;
    n_cmp++;
    if (grant_cnt8 !== 16'd0) begin
      n_bad++;
      $display("[TB] FAIL cnt_clear: got %0d expected 0", grant_cnt8);
    end
  endtask
`endif

  task automatic test_non_pow2();
    logic [31:0] d4;
    rst5 = 1'b1;
    bus5.MODE = MODE_FIXED; bus5.S = 3'd6; bus5.D_VALID = 5'h1F; bus5.Y_READY = 1'b1;
    for (int i = 0; i < 5; i++) bus5.D[i*32 +: 32] = $urandom;
    d4 = bus5.D[4*32 +: 32];
    @(posedge clk); #1;
    rst5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (bus5.D_READY !== 5'h00) begin
        n_bad++;
        $display("[TB] FAIL n5_s6_ready: got %h expected 00", bus5.D_READY);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus5.Y_VALID !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL n5_s6_valid: got %b expected 0", bus5.Y_VALID);
      end
    end
    bus5.S = 3'd4;
    #1;
    n_cmp++;
    if (bus5.D_READY !== 5'h10) begin
      n_bad++;
      $display("[TB] FAIL n5_s4_ready: got %h expected 10", bus5.D_READY);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus5.Y !== d4 || bus5.Y_SEL !== 3'd4 || bus5.Y_VALID !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL n5_s4_out: got %h/%0d/%b expected %h/4/1", bus5.Y, bus5.Y_SEL, bus5.Y_VALID, d4);
    end
    bus5.MODE = MODE_RR;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (bus5.D_READY !== 5'(1 << (k % 5))) begin
        n_bad++;
        $display("[TB] FAIL n5_rr_ready: got %h expected %h", bus5.D_READY, 5'(1 << (k % 5)));
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus5.Y_SEL !== 3'(k % 5)) begin
        n_bad++;
        $display("[TB] FAIL n5_rr_sel: got %0d expected %0d", bus5.Y_SEL, k % 5);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst8 = 1'b1; rst5 = 1'b1;
    bus8.D = '0; bus8.D_VALID = '0; bus8.MODE = MODE_FIXED; bus8.S = '0; bus8.Y_READY = 1'b0;
    bus5.D = '0; bus5.D_VALID = '0; bus5.MODE = MODE_FIXED; bus5.S = '0; bus5.Y_READY = 1'b0;
`ifdef MUX_GRANT_CNT_EN
    cnt_clr8 = 1'b0; cnt_clr5 = 1'b0;
`endif
    m_y = '0; m_yv = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    @(posedge clk); #1;

    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_sparse();
    test_backpressure();
    test_random();
`ifdef MUX_GRANT_CNT_EN
    test_grant_cnt();
`endif
    test_non_pow2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
